// File: rtl/imem_boot_loader.sv
// imem_boot_loader: loads a checksummed byte-stream image into imem and releases cpu_reset once the image checks good
module imem_boot_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  restart,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error
);
  localparam logic [2:0] LEN0 = 3'd0, LEN1 = 3'd1, DATA = 3'd2, CSUM = 3'd3, DONE = 3'd4, ERROR = 3'd5;
  localparam logic [16:0] CAP = 17'(1) << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] ONE = 1;
  logic [2:0]            state;
  logic [15:0]           len;
  logic [15:0]           len_n;
  logic [7:0]            csum;
  logic [1:0]            byte_idx;
  logic [23:0]           part;
  logic [ADDR_WIDTH:0]   word_idx;
  logic                  hs;
  logic                  last_word;
  logic                  oversize;
  logic                  csum_ok;
  always_comb begin
    in_ready  = state <= CSUM;
    hs        = in_valid && in_ready;
    len_n     = {in_data, len[7:0]};
    oversize  = {1'b0, len_n} > CAP;
    last_word = 17'(word_idx) + 17'd1 == {1'b0, len};
    csum_ok   = in_data == csum;
  end
  // Word index is one bit wider than the address so a full-capacity image never wraps.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state      <= LEN0;
      len        <= '0;
      csum       <= '0;
      byte_idx   <= '0;
      part       <= '0;
      word_idx   <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_reset  <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      if (hs)
        case (state)
          LEN0: begin
            len[7:0] <= in_data;
            state    <= LEN1;
          end
          LEN1: begin
            len[15:8] <= in_data;
            word_idx  <= '0;
            error     <= oversize;
            state     <= oversize ? ERROR : len_n == 16'd0 ? CSUM : DATA;
          end
          DATA: begin
            csum     <= csum ^ in_data;
            byte_idx <= byte_idx + 2'd1;
            part     <= {in_data, part[23:8]};
            if (byte_idx == 2'd3) begin
              imem_we    <= 1'b1;
              imem_addr  <= word_idx[ADDR_WIDTH-1:0];
              imem_wdata <= {in_data, part};
              word_idx   <= word_idx + ONE;
              if (last_word) state <= CSUM;
            end
          end
          CSUM: begin
            state     <= csum_ok ? DONE : ERROR;
            done      <= csum_ok;
            error     <= !csum_ok;
            cpu_reset <= !csum_ok;
          end
          default: ;
        endcase
      if (restart && (state == DONE || state == ERROR)) begin
        state     <= LEN0;
        len       <= '0;
        csum      <= '0;
        byte_idx  <= '0;
        part      <= '0;
        word_idx  <= '0;
        cpu_reset <= 1'b1;
        done      <= 1'b0;
        error     <= 1'b0;
      end
    end
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: random and directed frames checked against a frame-level model of the loader
module tb_imem_boot_loader;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        restart = 1'b0;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_reset;
  logic        done;
  logic        error;
  int errors = 0;
  int checks = 0;
  logic [39:0] got[$];
  imem_boot_loader #(.ADDR_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .restart(restart), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset), .done(done), .error(error)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (imem_we) got.push_back({imem_addr, imem_wdata});
  logic [7:0] t1[$] = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h33, 8'h81, 8'h10, 8'h00, 8'h61};
  task automatic run_frame(input logic [7:0] fr[$], input int gap, input string name);
    logic [39:0] exp[$];
    int n;
    logic [7:0] x;
    bit ok;
    n = {fr[1], fr[0]};
    x = '0;
    ok = 1'b0;
    if (n <= 256) begin
      for (int w = 0; w < n; w++)
        exp.push_back({8'(w), fr[4*w+5], fr[4*w+4], fr[4*w+3], fr[4*w+2]});
      for (int i = 2; i < 2 + 4 * n; i++) x ^= fr[i];
      ok = fr[2 + 4 * n] == x;
    end
    got.delete();
    for (int i = 0; i < fr.size(); i++) begin
      if (gap > 0)
        repeat ($urandom_range(0, gap)) begin
          in_valid = 1'b0;
          restart = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
      restart = 1'b0;
      if (i == fr.size() - 1) begin
        checks++;
        if (done !== 1'b0 || error !== 1'b0 || cpu_reset !== 1'b1)
          $display("FAIL %s early: done=%b error=%b cpu_reset=%b, required 0 0 1", name, done, error, cpu_reset);
        if (done !== 1'b0 || error !== 1'b0 || cpu_reset !== 1'b1) errors++;
      end
      in_valid = 1'b1;
      in_data = fr[i];
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    checks++;
    if (done !== ok || error !== !ok || cpu_reset !== !ok || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s status: done=%b error=%b cpu_reset=%b in_ready=%b, required done=%b error=%b cpu_reset=%b in_ready=0",
               name, done, error, cpu_reset, in_ready, ok, !ok, !ok);
    end
    checks++;
    if (got.size() != exp.size()) begin
      errors++;
      $display("FAIL %s write count: got %0d, required %0d", name, got.size(), exp.size());
    end else
      for (int i = 0; i < exp.size(); i++) begin
        checks++;
        if (got[i] !== exp[i]) begin
          errors++;
          $display("FAIL %s write %0d: addr/data %h, required %h", name, i, got[i], exp[i]);
        end
      end
  endtask
  task automatic do_restart(input string name);
    restart = 1'b1;
    @(posedge clk);
    #1;
    restart = 1'b0;
    checks++;
    if (cpu_reset !== 1'b1 || done !== 1'b0 || error !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s restart: cpu_reset=%b done=%b error=%b in_ready=%b, required 1 0 0 1",
               name, cpu_reset, done, error, in_ready);
    end
  endtask
  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({cpu_reset, done, error, imem_we, in_ready} !== 5'b10001 || imem_addr !== 8'h00 || imem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset: cpu_reset/done/error/we/ready=%b addr=%h wdata=%h, required 10001 00 00000000",
               {cpu_reset, done, error, imem_we, in_ready}, imem_addr, imem_wdata);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask
  task automatic test_basic();
    run_frame(t1, 0, "basic");
    do_restart("basic");
  endtask
  task automatic test_bad_csum();
    logic [7:0] fr[$];
    fr = t1;
    fr[10] = 8'h60;
    run_frame(fr, 0, "bad_csum");
    do_restart("bad_csum");
  endtask
  task automatic test_empty();
    logic [7:0] fr[$] = '{8'h00, 8'h00, 8'h00};
    run_frame(fr, 0, "empty");
    do_restart("empty");
  endtask
  task automatic test_oversize();
    logic [7:0] fr[$] = '{8'h01, 8'h01};
    run_frame(fr, 0, "oversize");
    do_restart("oversize");
  endtask
  task automatic test_full();
    logic [7:0] fr[$];
    logic [7:0] x = '0;
    logic [7:0] b;
    fr = '{8'h00, 8'h01};
    for (int i = 0; i < 1024; i++) begin
      b = 8'($urandom);
      x ^= b;
      fr.push_back(b);
    end
    fr.push_back(x);
    run_frame(fr, 0, "full");
    checks++;
    if (got.size() == 0 || got[got.size()-1][39:32] !== 8'hFF) begin
      errors++;
      $display("FAIL full last addr: got %0d writes, required last addr ff", got.size());
    end
    do_restart("full");
  endtask
  task automatic test_gaps();
    run_frame(t1, 3, "gaps_t1");
    do_restart("gaps_t1");
    for (int f = 0; f < 8; f++) begin
      logic [7:0] fr[$];
      logic [7:0] x = '0;
      logic [7:0] b;
      int n = $urandom_range(1, 6);
      fr = '{8'(n), 8'h00};
      for (int i = 0; i < 4 * n; i++) begin
        b = 8'($urandom);
        x ^= b;
        fr.push_back(b);
      end
      fr.push_back($urandom_range(0, 1) ? x : x ^ 8'(1 << $urandom_range(0, 7)));
      run_frame(fr, 3, "gaps_rand");
      do_restart("gaps_rand");
    end
  endtask
  task automatic test_mid_reset();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data = t1[i];
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #2;
    checks++;
    if (cpu_reset !== 1'b1 || imem_we !== 1'b0 || in_ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: cpu_reset=%b we=%b in_ready=%b done=%b, required 1 0 1 0", cpu_reset, imem_we, in_ready, done);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    run_frame(t1, 0, "mid_reset_replay");
  endtask
  initial begin
    test_reset();
    test_basic();
    test_bad_csum();
    test_empty();
    test_oversize();
    test_full();
    test_gaps();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
